// File: rtl/shifter_ctl.sv
// Sequencer/configurator for the pipelined mask-compaction shifter: serial shift-distance
// calculation, pipeline drain on reconfigure/stop. Optional macro SHIFTER_CTL_POPCNT_EN adds cfg_count.
module shifter_ctl #(
  parameter int DW = 32,
  parameter int DL = $clog2(DW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DW-1:0]    cfg_mask,
  input  logic             run,
  input  logic             sti_xfer,
  input  logic             sto_xfer,
  output logic             sti_hold,
  output logic             ctl_clr,
  output logic             ctl_ena,
  output logic [DW*DL-1:0] shift,
  output logic             busy,
  output logic             err,
`ifdef SHIFTER_CTL_POPCNT_EN
  output logic [DL:0]      cfg_count,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN, S_DRAIN} state_t;

  localparam logic [DL-1:0] J_LAST  = DL'(DW - 1);
  localparam logic [DL:0]   OUT_MAX = (DL + 1)'(DL);

  state_t             state, state_nxt;
  logic [DW-1:0]      m;
  logic [DL-1:0]      j;
  logic [DL:0]        k, k_nxt;
  logic [DW*DL-1:0]   d, d_nxt;
  logic               pend;
  logic               mask_vld;
  logic [DL:0]        outst, outst_nxt;
  logic               cnt_err;
  logic               accept;

  // A mask transfers on any cycle where cfg_valid and cfg_ready are both high;
  // cfg_mask must be stable while cfg_valid is high and not yet accepted.
  assign accept    = cfg_valid & cfg_ready;
  assign state_dbg = state;

  always_comb begin
    d_nxt = d;
    k_nxt = k;
    if (m[j]) begin
      d_nxt[k[DL-1:0]*DL +: DL] = j - k[DL-1:0];
      k_nxt = k + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept)                state_nxt = S_CALC;
        else if (run && mask_vld)  state_nxt = S_RUN;
      end
      S_CALC: begin
        if (j == J_LAST)           state_nxt = run ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (accept || !run)        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst == '0)           state_nxt = pend ? S_CALC : S_IDLE;
      end
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Outstanding items inside the shifter; saturates at DL rather than wrapping.
  always_comb begin
    outst_nxt = outst;
    cnt_err   = 1'b0;
    if (sti_xfer && !sto_xfer) begin
      if (outst == OUT_MAX) cnt_err   = 1'b1;
      else                  outst_nxt = outst + 1'b1;
    end else if (sto_xfer && !sti_xfer) begin
      if (outst == '0)      cnt_err   = 1'b1;
      else                  outst_nxt = outst - 1'b1;
    end
    if (sti_xfer && state != S_RUN) cnt_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
      sti_hold  <= 1'b1;
      ctl_clr   <= 1'b0;
      ctl_ena   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      shift     <= '0;
      outst     <= '0;
      m         <= '0;
      j         <= '0;
      k         <= '0;
      d         <= '0;
      pend      <= 1'b0;
      mask_vld  <= 1'b0;
`ifdef SHIFTER_CTL_POPCNT_EN
      cfg_count <= '0;
`endif
    end else begin
      state     <= state_nxt;
      outst     <= outst_nxt;
      if (cnt_err) err <= 1'b1;

      ctl_clr   <= (state_nxt == S_CALC) && (state != S_CALC);
      ctl_ena   <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      sti_hold  <= (state_nxt != S_RUN);
      busy      <= (state_nxt == S_CALC) || (state_nxt == S_DRAIN);
      cfg_ready <= (state_nxt == S_IDLE) || ((state_nxt == S_RUN) && !pend);

      if (accept) m <= cfg_mask;

      if (state == S_RUN && accept)
        pend <= 1'b1;
      else if (state == S_DRAIN && state_nxt == S_CALC)
        pend <= 1'b0;

      // The last scan step folds its own bit into shift so the update is atomic.
      if (state_nxt == S_CALC && state != S_CALC) begin
        j <= '0;
        k <= '0;
        d <= '0;
      end else if (state == S_CALC) begin
        j <= j + 1'b1;
        k <= k_nxt;
        d <= d_nxt;
        if (j == J_LAST) begin
          shift    <= d_nxt;
          mask_vld <= 1'b1;
`ifdef SHIFTER_CTL_POPCNT_EN
          cfg_count <= k_nxt;
`endif
        end
      end
    end
  end

endmodule
